// File: rtl/imm_packer.sv
// Packs a signed immediate into the I/S/B/J field layout of a base instruction, flags range and
// alignment problems, and queues the result in a 2-entry valid/ready buffer. Optional: IMM_PACKER_ERR_CNT_EN.
module imm_packer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] IMMEDIATE,
    input  logic [1:0]       immsrc,
    input  logic [WIDTH-1:0] BASE_INSTRUCTION,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] INSTRUCTION_OUT,
    output logic             range_err,
    output logic             align_err
`ifdef IMM_PACKER_ERR_CNT_EN
    ,
    output logic [15:0]      err_count
`endif
);

    localparam logic [1:0] FMT_I = 2'b00;
    localparam logic [1:0] FMT_S = 2'b01;
    localparam logic [1:0] FMT_B = 2'b10;
    localparam logic [1:0] FMT_J = 2'b11;

    typedef struct packed {
        logic [WIDTH-1:0] instr;
        logic             range_err;
        logic             align_err;
    } beat_t;

    function automatic logic [WIDTH-1:0] pack_fields(input logic [WIDTH-1:0] imm,
                                                      input logic [1:0]       fmt,
                                                      input logic [WIDTH-1:0] base);
        logic [WIDTH-1:0] res;
        res = base;
        case (fmt)
            FMT_I: res[31:20] = imm[11:0];
            FMT_S: begin
                res[31:25] = imm[11:5];
                res[11:7]  = imm[4:0];
            end
            FMT_B: begin
                res[31]    = imm[12];
                res[30:25] = imm[10:5];
                res[11:8]  = imm[4:1];
                res[7]     = imm[11];
            end
            FMT_J: begin
                res[31]    = imm[20];
                res[30:21] = imm[10:1];
                res[20]    = imm[11];
                res[19:12] = imm[19:12];
            end
            default: res = base;
        endcase
        return res;
    endfunction

    // The immediate fits when every bit above the format's sign bit copies that sign bit.
    function automatic logic out_of_range(input logic [WIDTH-1:0] imm, input logic [1:0] fmt);
        logic bad;
        case (fmt)
            FMT_I, FMT_S: bad = !((&imm[31:11]) || !(|imm[31:11]));
            FMT_B:        bad = !((&imm[31:12]) || !(|imm[31:12]));
            FMT_J:        bad = !((&imm[31:20]) || !(|imm[31:20]));
            default:      bad = 1'b0;
        endcase
        return bad;
    endfunction

    beat_t      head_q, head_d;
    beat_t      tail_q, tail_d;
    logic [1:0] count_q, count_d;
    beat_t      new_beat_s;
    logic       push_s;
    logic       pop_s;

    assign in_ready        = (count_q != 2'd2);
    assign out_valid       = (count_q != 2'd0);
    assign INSTRUCTION_OUT = head_q.instr;
    assign range_err       = head_q.range_err;
    assign align_err       = head_q.align_err;

    assign push_s = in_valid && in_ready;
    assign pop_s  = out_valid && out_ready;

    assign new_beat_s.instr     = pack_fields(IMMEDIATE, immsrc, BASE_INSTRUCTION);
    assign new_beat_s.range_err = out_of_range(IMMEDIATE, immsrc);
    assign new_beat_s.align_err = immsrc[1] && IMMEDIATE[0];

    // Buffer next-state: head is the output register, tail holds the second beat when full.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = new_beat_s;
                end else begin
                    tail_d = new_beat_s;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                end else begin
                    head_d = head_q;
                end
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = new_beat_s;
                end else begin
                    head_d = tail_q;
                    tail_d = new_beat_s;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // Buffer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

`ifdef IMM_PACKER_ERR_CNT_EN
    logic [15:0] err_count_q, err_count_d;

    assign err_count = err_count_q;

    // One count per accepted beat carrying any error flag, saturating.
    always_comb begin
        err_count_d = err_count_q;
        if (push_s && (new_beat_s.range_err || new_beat_s.align_err) && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= 16'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_imm_packer.sv
// Scoreboard bench for imm_packer: expectations are queued at push and checked at pop by
// independently decoding the packed instruction back into an immediate.
module tb_imm_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] IMMEDIATE = 32'd0;
    logic [1:0]  immsrc = 2'd0;
    logic [31:0] BASE_INSTRUCTION = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] INSTRUCTION_OUT;
    logic        range_err;
    logic        align_err;
`ifdef IMM_PACKER_ERR_CNT_EN
    logic [15:0] err_count;
`endif

    typedef struct {
        logic [31:0] imm;
        logic [1:0]  src;
        logic [31:0] base;
        bit          has_exact;
        logic [31:0] exact;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          pops = 0;
    int          exp_err = 0;
    bit          rand_bp = 1'b0;
    bit          cur_has_exact = 1'b0;
    logic [31:0] cur_exact = 32'd0;

    imm_packer #(.WIDTH(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .IMMEDIATE        (IMMEDIATE),
        .immsrc           (immsrc),
        .BASE_INSTRUCTION (BASE_INSTRUCTION),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .INSTRUCTION_OUT  (INSTRUCTION_OUT),
        .range_err        (range_err),
        .align_err        (align_err)
`ifdef IMM_PACKER_ERR_CNT_EN
        ,
        .err_count        (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected sign-extended value recoverable from the format (arithmetic form).
    function automatic logic [31:0] exp_decode(input logic [31:0] imm, input logic [1:0] src);
        logic signed [31:0] s;
        s = imm;
        case (src)
            2'd0, 2'd1: return 32'((s <<< 20) >>> 20);
            2'd2:       return 32'((s <<< 19) >>> 19) & ~32'd1;
            default:    return 32'((s <<< 11) >>> 11) & ~32'd1;
        endcase
    endfunction

    // Decode-side immediate extraction from a packed instruction.
    function automatic logic [31:0] dut_decode(input logic [31:0] i, input logic [1:0] src);
        case (src)
            2'd0:    return {{20{i[31]}}, i[31:20]};
            2'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            2'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    function automatic logic [31:0] imm_mask(input logic [1:0] src);
        case (src)
            2'd0:       return 32'hFFF0_0000;
            2'd1, 2'd2: return 32'hFE00_0F80;
            default:    return 32'hFFFF_F000;
        endcase
    endfunction

    function automatic bit exp_range(input logic [31:0] imm, input logic [1:0] src);
        int v;
        v = $signed(imm);
        case (src)
            2'd0, 2'd1: return (v < -2048) || (v > 2047);
            2'd2:       return (v < -4096) || (v > 4095);
            default:    return (v < -1048576) || (v > 1048575);
        endcase
    endfunction

    // Scoreboard monitor: pop/compare before push since a same-edge pop sees the older head.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            exp_err = 0;
        end else begin
            if (out_valid && out_ready) begin
                pops++;
                check_eq("beat_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("range_err", 32'(range_err), 32'(exp_range(e.imm, e.src)));
                    check_eq("align_err", 32'(align_err), 32'(e.src[1] & e.imm[0]));
                    check_eq("decode", dut_decode(INSTRUCTION_OUT, e.src), exp_decode(e.imm, e.src));
                    check_eq("base_bits", INSTRUCTION_OUT & ~imm_mask(e.src), e.base & ~imm_mask(e.src));
                    if (e.has_exact) begin
                        check_eq("exact", INSTRUCTION_OUT, e.exact);
                    end
                end
            end
            if (in_valid && in_ready) begin
                e.imm       = IMMEDIATE;
                e.src       = immsrc;
                e.base      = BASE_INSTRUCTION;
                e.has_exact = cur_has_exact;
                e.exact     = cur_exact;
                sb.push_back(e);
                if ((exp_range(IMMEDIATE, immsrc) || (immsrc[1] && IMMEDIATE[0])) && exp_err < 65535) begin
                    exp_err++;
                end
            end
        end
    end

    // Called and returns at posedge+1; holds the request until accepted or the budget runs out.
    task automatic send(input logic [31:0] imm, input logic [1:0] src, input logic [31:0] base,
                        input bit has_ex, input logic [31:0] ex);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        IMMEDIATE = imm;
        immsrc = src;
        BASE_INSTRUCTION = base;
        cur_has_exact = has_ex;
        cur_exact = ex;
        for (int c = 0; c < 1000 && !ok; c++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        check_eq("send_accept", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            done = (sb.size() == 0) && !out_valid;
        end
        check_eq("drain", 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        logic [31:0] r;
        int sh;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_instr", INSTRUCTION_OUT, 32'd0);
        check_eq("rst_flags", 32'({range_err, align_err}), 32'd0);
`ifdef IMM_PACKER_ERR_CNT_EN
        check_eq("rst_err_count", 32'(err_count), 32'd0);
`endif
        @(posedge clk);
        #1;

        // I format, one-cycle latency
        out_ready = 1'b1;
        send(32'hFFFF_FFFF, 2'd0, 32'h0000_0013, 1'b1, 32'hFFF0_0013);
        @(negedge clk);
        check_eq("i_latency_valid", 32'(out_valid), 32'd1);
        check_eq("i_latency_data", INSTRUCTION_OUT, 32'hFFF0_0013);
        @(posedge clk);
        #1;
        drain();

        // S then B back-to-back, out_valid continuous
        send(32'd8, 2'd1, 32'h0000_2023, 1'b1, 32'h0000_2423);
        fork
            send(32'hFFFF_FFFC, 2'd2, 32'h0000_0063, 1'b1, 32'hFE00_0EE3);
            begin
                @(negedge clk);
                check_eq("sb_valid0", 32'(out_valid), 32'd1);
                check_eq("sb_data0", INSTRUCTION_OUT, 32'h0000_2423);
                @(negedge clk);
                check_eq("sb_valid1", 32'(out_valid), 32'd1);
                check_eq("sb_data1", INSTRUCTION_OUT, 32'hFE00_0EE3);
            end
        join
        @(posedge clk);
        #1;
        drain();

        // J and error beats
        send(32'd2048, 2'd3, 32'h0000_006F, 1'b1, 32'h0010_006F);
        send(32'd2048, 2'd0, 32'h0000_0013, 1'b1, 32'h8000_0013);
        send(32'd3,    2'd2, 32'h0000_0063, 1'b1, 32'h0000_0163);
        drain();
`ifdef IMM_PACKER_ERR_CNT_EN
        check_eq("err_count_directed", 32'(err_count), 32'd2);
`endif

        // Backpressure: two accepted, third waits, head stable
        p0 = pops;
        out_ready = 1'b0;
        send(32'd1, 2'd0, 32'h0000_0013, 1'b1, 32'h0010_0013);
        send(32'd2, 2'd0, 32'h0000_0013, 1'b1, 32'h0020_0013);
        fork
            send(32'd3, 2'd0, 32'h0000_0013, 1'b1, 32'h0030_0013);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check_eq("bp_in_ready", 32'(in_ready), 32'd0);
                    check_eq("bp_head_valid", 32'(out_valid), 32'd1);
                    check_eq("bp_head_stable", INSTRUCTION_OUT, 32'h0010_0013);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check_eq("bp_delivered", 32'(pops - p0), 32'd3);

        // Reset with two beats buffered
        out_ready = 1'b0;
        send(32'd7, 2'd1, 32'h0000_2023, 1'b0, 32'd0);
        send(32'hFFFF_FFFF, 2'd0, 32'h0000_0013, 1'b0, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("mid_rst_instr", INSTRUCTION_OUT, 32'd0);
        @(posedge clk);
        #1;
        p0 = pops;
        out_ready = 1'b1;
        send(32'd5, 2'd0, 32'h0000_0013, 1'b1, 32'h0050_0013);
        drain();
        check_eq("mid_rst_single", 32'(pops - p0), 32'd1);

        // Randomised round trip with random backpressure
        rand_bp = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            r = $urandom;
            case ($urandom_range(0, 3))
                0: sh = 0;
                1: sh = 20;
                2: sh = 19;
                default: sh = 11;
            endcase
            send(32'($signed(r << sh) >>> sh), 2'($urandom_range(0, 3)), $urandom, 1'b0, 32'd0);
        end
        rand_bp = 1'b0;
        out_ready = 1'b1;
        drain();
`ifdef IMM_PACKER_ERR_CNT_EN
        check_eq("err_count_random", 32'(err_count), 32'(exp_err));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
